// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch condition codes and branch resolver state encoding.
//   COND_*      3-bit condition codes carried on br_cond
//   br_state_t  resolver FSM states BR_IDLE..BR_FLUSH
package cpu_pkg;

   localparam logic [2:0] COND_ALWAYS = 3'b000;
   localparam logic [2:0] COND_Z      = 3'b001;
   localparam logic [2:0] COND_NZ     = 3'b010;
   localparam logic [2:0] COND_C      = 3'b011;
   localparam logic [2:0] COND_NC     = 3'b100;
   localparam logic [2:0] COND_HI     = 3'b101;
   localparam logic [2:0] COND_LS     = 3'b110;
   localparam logic [2:0] COND_NEVER  = 3'b111;

   typedef enum logic [1:0] {
      BR_IDLE,
      BR_WAIT_FLAGS,
      BR_EVAL,
      BR_FLUSH
   } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational evaluation of a branch condition code against the flags.
//   cond   in  3  condition code (COND_*)
//   c      in  1  carry flag
//   z      in  1  zero flag
//   taken  out 1  1 when the condition holds
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       c,
   input  logic       z,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_ALWAYS: taken = 1'b1;
         COND_Z:      taken = z;
         COND_NZ:     taken = !z;
         COND_C:      taken = c;
         COND_NC:     taken = !c;
         COND_HI:     taken = !c && !z;
         COND_LS:     taken = c || z;
         COND_NEVER:  taken = 1'b0;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves conditional branches against stored flags, loads the PC and flushes.
//   clk, reset             clock, synchronous active-high reset
//   br_valid/br_ready      request handshake; accepted only in IDLE
//   br_cond, br_target     condition code and target, captured on accept
//   flag_load              flags update at the next edge; forces a one-cycle wait
//   carry_flag, zero_flag  stored flags, sampled in EVAL
//   pc_load, pc_target     one-cycle PC load pulse and captured target
//   flush                  high FLUSH_CYCLES cycles starting with pc_load
//   stall                  high whenever not IDLE
//   br_done, br_taken      one-cycle resolution pulse and outcome
//   taken_cnt, ntaken_cnt  saturating statistics
module branch_resolver
   import cpu_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [2:0]        br_cond,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              flag_load,
   input  logic              carry_flag,
   input  logic              zero_flag,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_target,
   output logic              flush,
   output logic              stall,
   output logic              br_done,
   output logic              br_taken,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  ntaken_cnt
);

   // The first FLUSH cycle is counted at load time, so the counter starts one short.
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   br_state_t  state, state_nxt;
   logic [2:0] cond;
   logic [3:0] flush_cnt;
   logic       cond_true;
   logic       accept;
   logic       resolve;

   branch_cond_eval u_eval (
      .cond  (cond),
      .c     (carry_flag),
      .z     (zero_flag),
      .taken (cond_true)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      resolve   = 1'b0;
      case (state)
         BR_IDLE: begin
            accept    = br_valid;
            state_nxt = !br_valid ? BR_IDLE : flag_load ? BR_WAIT_FLAGS : BR_EVAL;
         end
         BR_WAIT_FLAGS: state_nxt = BR_EVAL;
         BR_EVAL: begin
            resolve   = 1'b1;
            state_nxt = cond_true ? BR_FLUSH : BR_IDLE;
         end
         BR_FLUSH: state_nxt = (flush_cnt == 4'd0) ? BR_IDLE : BR_FLUSH;
         default:  state_nxt = BR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BR_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cond       <= COND_ALWAYS;
         pc_target  <= '0;
         flush_cnt  <= 4'd0;
         pc_load    <= 1'b0;
         br_done    <= 1'b0;
         br_taken   <= 1'b0;
         taken_cnt  <= '0;
         ntaken_cnt <= '0;
      end else begin
         if (accept) begin
            cond      <= br_cond;
            pc_target <= br_target;
         end
         flush_cnt <= (resolve && cond_true) ? FLUSH_LOAD :
                      (state == BR_FLUSH && flush_cnt != 4'd0) ? flush_cnt - 4'd1 : flush_cnt;
         pc_load  <= resolve && cond_true;
         br_done  <= resolve;
         br_taken <= resolve && cond_true;
         if (resolve && cond_true && taken_cnt != '1)
            taken_cnt <= taken_cnt + 1'b1;
         if (resolve && !cond_true && ntaken_cnt != '1)
            ntaken_cnt <= ntaken_cnt + 1'b1;
      end
   end

   assign flush    = (state == BR_FLUSH);
   assign stall    = (state != BR_IDLE);
   assign br_ready = (state == BR_IDLE);

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: randomized self-checking bench for branch_resolver against a transaction model.
//   Drives a default instance and a narrow-counter instance from the same stimulus.
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        br_valid = 1'b0;
   logic [2:0]  br_cond = 3'd0;
   logic [15:0] br_target = 16'd0;
   logic        flag_load = 1'b0;
   logic        carry_flag = 1'b0;
   logic        zero_flag = 1'b0;

   logic        br_ready, pc_load, flush, stall, br_done, br_taken;
   logic [15:0] pc_target, taken_cnt, ntaken_cnt;
   logic        s_br_ready, s_pc_load, s_flush, s_stall, s_br_done, s_br_taken;
   logic [15:0] s_pc_target;
   logic [3:0]  s_taken_cnt, s_ntaken_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int n_t = 0;
   int n_nt = 0;

   always #5 clk = ~clk;

   branch_resolver dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
      .br_cond(br_cond), .br_target(br_target), .flag_load(flag_load),
      .carry_flag(carry_flag), .zero_flag(zero_flag), .pc_load(pc_load),
      .pc_target(pc_target), .flush(flush), .stall(stall), .br_done(br_done),
      .br_taken(br_taken), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
   );

   branch_resolver #(.ADDR_W(16), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(s_br_ready),
      .br_cond(br_cond), .br_target(br_target), .flag_load(flag_load),
      .carry_flag(carry_flag), .zero_flag(zero_flag), .pc_load(s_pc_load),
      .pc_target(s_pc_target), .flush(s_flush), .stall(s_stall), .br_done(s_br_done),
      .br_taken(s_br_taken), .taken_cnt(s_taken_cnt), .ntaken_cnt(s_ntaken_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic ref_taken(input logic [2:0] cond, input logic c, input logic z);
      case (cond)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return c;
         3'd4: return !c;
         3'd5: return !c && !z;
         3'd6: return c || z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat15(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic check_counts();
      check("taken_cnt", 32'(taken_cnt), 32'(n_t));
      check("ntaken_cnt", 32'(ntaken_cnt), 32'(n_nt));
      check("sat_taken_cnt", 32'(s_taken_cnt), 32'(sat15(n_t)));
      check("sat_ntaken_cnt", 32'(s_ntaken_cnt), 32'(sat15(n_nt)));
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge where br_ready is next high.
   task automatic do_branch(input logic [2:0] cond, input logic [15:0] tgt, input logic fl,
                            input logic c0, input logic z0, input logic nc, input logic nz,
                            input logic hold);
      int lat, done_at, pl_at, pl_n, f_n, f_first, rdy_at;
      logic tk, exp;
      logic [15:0] t_seen;
      done_at = -1; pl_at = -1; pl_n = 0; f_n = 0; f_first = -1; rdy_at = -1;
      tk = 1'b0; t_seen = 16'd0;
      carry_flag = c0; zero_flag = z0;
      br_valid = 1'b1; br_cond = cond; br_target = tgt; flag_load = fl;
      check("ready_at_request", 32'(br_ready), 32'd1);
      @(posedge clk); #1;
      flag_load = 1'b0;
      if (!hold) br_valid = 1'b0;
      if (fl) begin
         carry_flag = nc; zero_flag = nz;
      end
      exp = ref_taken(cond, carry_flag, zero_flag);
      lat = fl ? 3 : 2;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) check("stall_after_accept", 32'(stall), 32'd1);
         if (br_done) begin
            done_at = c; tk = br_taken;
         end
         if (pc_load) begin
            pl_n++; pl_at = c; t_seen = pc_target;
         end
         if (flush) begin
            if (f_n == 0) f_first = c;
            f_n++;
         end
         if (br_ready) begin
            rdy_at = c;
            break;
         end
      end
      if (exp) n_t++; else n_nt++;
      check("done_latency", 32'(done_at), 32'(lat));
      check("br_taken", 32'(tk), 32'(exp));
      check("pc_load_count", 32'(pl_n), exp ? 32'd1 : 32'd0);
      check("flush_cycles", 32'(f_n), exp ? 32'd2 : 32'd0);
      check("ready_cycle", 32'(rdy_at), exp ? 32'(lat + 2) : 32'(lat));
      if (exp) begin
         check("pc_load_cycle", 32'(pl_at), 32'(lat));
         check("pc_target", 32'(t_seen), 32'(tgt));
         check("flush_start", 32'(f_first), 32'(lat));
      end
      check_counts();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(br_ready), 32'd1);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_outputs", {28'd0, pc_load, flush, br_done, br_taken}, 32'd0);
      check("rst_pc_target", 32'(pc_target), 32'd0);
      check_counts();

      // Z set, target 0x0040 -> taken; then C clear -> not taken, accepted back to back.
      do_branch(3'b001, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      do_branch(3'b011, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_branch(3'b011, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // !Z with flag update Z 0->1 during the wait -> not taken after 3 cycles.
      do_branch(3'b010, 16'h0BAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int cd = 0; cd < 8; cd++)
         for (int f = 0; f < 4; f++)
            do_branch(3'(cd), 16'($urandom), 1'b0, f[1], f[0], 1'b0, 1'b0, 1'b0);

      // Reset on the first FLUSH cycle.
      br_valid = 1'b1; br_cond = 3'b000; br_target = 16'hBEEF;
      @(posedge clk); #1 br_valid = 1'b0;
      for (int i = 0; i < 10 && !br_done; i++) @(negedge clk);
      check("mid_flush_flush_before", 32'(flush), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      n_t = 0; n_nt = 0;
      check("mid_flush_flush", 32'(flush), 32'd0);
      check("mid_flush_stall", 32'(stall), 32'd0);
      check("mid_flush_ready", 32'(br_ready), 32'd1);
      check("mid_flush_pc_load", 32'(pc_load), 32'd0);
      check_counts();
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 150; i++)
         do_branch(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      br_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_stall", 32'(stall), 32'd0);
      check_counts();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
